// File: rtl/branch_ctrl_if.sv
// Bundles the branch_ctrl operand/branch request inputs, redirect/stall outputs and perf counters.
// The pipeline side uses the master modport and branch_ctrl uses the slave modport.
interface branch_ctrl_if;
   logic        br_valid;
   logic [3:0]  br_op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        rs_ready;
   logic        rt_ready;
   logic [31:0] pc_id;
   logic [15:0] imm16;
   logic        id_hold;
   logic        br_stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        slot_kill;
   logic        slot_err;
   logic [31:0] br_cnt;
   logic [31:0] taken_cnt;
   logic [31:0] stall_cnt;

   modport master (
      output br_valid, br_op, rs_data, rt_data, rs_ready, rt_ready, pc_id, imm16, id_hold,
      input  br_stall, redirect_valid, redirect_pc, slot_kill, slot_err,
             br_cnt, taken_cnt, stall_cnt
   );

   modport slave (
      input  br_valid, br_op, rs_data, rt_data, rs_ready, rt_ready, pc_id, imm16, id_hold,
      output br_stall, redirect_valid, redirect_pc, slot_kill, slot_err,
             br_cnt, taken_cnt, stall_cnt
   );
endinterface

// File: rtl/branch_ctrl.sv
// ID-stage branch resolution: operand wait, condition evaluation, PC redirect and delay-slot tracking.
// Define BRANCH_CTRL_PERF_EN to build the br/taken/stall performance counters; otherwise they read 0.
module branch_ctrl (
   input logic          clk,
   input logic          reset,
   branch_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT, SLOT} stateT;

   stateT       state;
   logic        killPend;
   logic        slotFirst;
   logic [2:0]  cond;
   logic        likely;
   logic        needsRt;
   logic        reserved;
   logic        ready;
   logic        taken;
   logic        rsNeg;
   logic        rsZero;
   logic        deciding;
   logic        stallNow;
   logic        decideNow;
   logic        consume;
   logic [31:0] targetPc;

   // Ops 6/7 count as ready so they never stall; they resolve as not-taken decisions.
   always_comb begin
      cond      = bus.br_op[2:0];
      likely    = bus.br_op[3];
      needsRt   = (cond == 3'd0) || (cond == 3'd1);
      reserved  = cond[2] & cond[1];
      ready     = reserved || (bus.rs_ready && (bus.rt_ready || !needsRt));
      rsNeg     = bus.rs_data[31];
      rsZero    = (bus.rs_data == 32'h0);
      taken     = 1'b0;
      case (cond)
         3'd0:    taken = (bus.rs_data == bus.rt_data);
         3'd1:    taken = (bus.rs_data != bus.rt_data);
         3'd2:    taken = rsNeg || rsZero;
         3'd3:    taken = !rsNeg && !rsZero;
         3'd4:    taken = rsNeg;
         3'd5:    taken = !rsNeg;
         default: taken = 1'b0;
      endcase
      deciding  = (state != SLOT) && bus.br_valid;
      stallNow  = deciding && !ready;
      decideNow = deciding && ready;
      consume   = decideNow && !bus.id_hold;
      targetPc  = bus.pc_id + 32'd4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         killPend  <= 1'b0;
         slotFirst <= 1'b0;
      end else begin
         case (state)
            IDLE, WAIT: begin
               if (!bus.br_valid) begin
                  state <= IDLE;
               end else if (!ready) begin
                  state <= WAIT;
               end else if (!bus.id_hold) begin
                  state     <= SLOT;
                  killPend  <= likely && !taken;
                  slotFirst <= 1'b1;
               end
            end
            SLOT: begin
               slotFirst <= 1'b0;
               if (!bus.id_hold) begin
                  state    <= IDLE;
                  killPend <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               killPend <= 1'b0;
            end
         endcase
      end
   end

   // Every output is masked while reset is held low, independent of the inputs.
   assign bus.br_stall       = reset && stallNow;
   assign bus.redirect_valid = reset && decideNow && taken;
   assign bus.redirect_pc    = reset ? targetPc : 32'h0;
   assign bus.slot_kill      = reset && (state == SLOT) && killPend;
   assign bus.slot_err       = reset && (state == SLOT) && slotFirst && bus.br_valid;

`ifdef BRANCH_CTRL_PERF_EN
   logic [31:0] brCnt;
   logic [31:0] takenCnt;
   logic [31:0] stallCnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         brCnt    <= 32'h0;
         takenCnt <= 32'h0;
         stallCnt <= 32'h0;
      end else begin
         if (consume) begin
            brCnt <= brCnt + 32'd1;
         end
         if (consume && taken) begin
            takenCnt <= takenCnt + 32'd1;
         end
         if (stallNow) begin
            stallCnt <= stallCnt + 32'd1;
         end
      end
   end

   assign bus.br_cnt    = reset ? brCnt    : 32'h0;
   assign bus.taken_cnt = reset ? takenCnt : 32'h0;
   assign bus.stall_cnt = reset ? stallCnt : 32'h0;
`else
   assign bus.br_cnt    = 32'h0;
   assign bus.taken_cnt = 32'h0;
   assign bus.stall_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_branch_ctrl.sv
// Testbench for branch_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Counter expectations follow BRANCH_CTRL_PERF_EN in the same way as the design.
module tb_branch_ctrl;
`ifdef BRANCH_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   branch_ctrl_if bus ();

   branch_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: only "are we in the delay slot" matters, plus the slot flags and counts.
   bit          mInSlot;
   bit          mKill;
   bit          mSlotFirst;
   int unsigned mBr;
   int unsigned mTaken;
   int unsigned mStall;

   function automatic bit modelTaken(logic [3:0] op, logic [31:0] rs, logic [31:0] rt);
      int s;
      s = $signed(rs);
      case (op[2:0])
         3'd0:    return rs == rt;
         3'd1:    return rs != rt;
         3'd2:    return s <= 0;
         3'd3:    return s > 0;
         3'd4:    return s < 0;
         3'd5:    return s >= 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit modelReady(logic [3:0] op, logic rsr, logic rtr);
      if (op[2:0] >= 3'd6) return 1'b1;
      return rsr && (rtr || (op[2:0] > 3'd1));
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives one cycle of inputs after the falling edge and checks every output against the model.
   task automatic applyStimulus(input logic rstN, input logic bv, input logic [3:0] op,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic rsr, input logic rtr,
                                input logic [31:0] pc, input logic [15:0] imm, input logic hold);
      bit          eStall;
      bit          eRedir;
      bit          eKill;
      bit          eErr;
      logic [31:0] ePc;
      @(negedge clk);
      reset        = rstN;
      bus.br_valid = bv;
      bus.br_op    = op;
      bus.rs_data  = rs;
      bus.rt_data  = rt;
      bus.rs_ready = rsr;
      bus.rt_ready = rtr;
      bus.pc_id    = pc;
      bus.imm16    = imm;
      bus.id_hold  = hold;
      #1;
      eStall = 1'b0;
      eRedir = 1'b0;
      eKill  = 1'b0;
      eErr   = 1'b0;
      ePc    = pc + 32'd4 + 32'(int'($signed(imm)) * 4);
      if (rstN) begin
         if (mInSlot) begin
            eKill = mKill;
            eErr  = mSlotFirst && bv;
         end else if (bv) begin
            eStall = !modelReady(op, rsr, rtr);
            eRedir = !eStall && modelTaken(op, rs, rt);
         end
      end
      checkOutput("br_stall", {31'h0, bus.br_stall}, {31'h0, eStall});
      checkOutput("redirect_valid", {31'h0, bus.redirect_valid}, {31'h0, eRedir});
      checkOutput("slot_kill", {31'h0, bus.slot_kill}, {31'h0, eKill});
      checkOutput("slot_err", {31'h0, bus.slot_err}, {31'h0, eErr});
      if (!rstN) begin
         checkOutput("redirect_pc_rst", bus.redirect_pc, 32'h0);
      end else if (eRedir) begin
         checkOutput("redirect_pc", bus.redirect_pc, ePc);
      end
      checkOutput("br_cnt", bus.br_cnt, (rstN && PERF) ? mBr : 32'h0);
      checkOutput("taken_cnt", bus.taken_cnt, (rstN && PERF) ? mTaken : 32'h0);
      checkOutput("stall_cnt", bus.stall_cnt, (rstN && PERF) ? mStall : 32'h0);
   endtask

   // Advances through the rising edge and moves the model by the same rules.
   task automatic endCycle();
      bit rdy;
      bit tk;
      @(posedge clk);
      rdy = modelReady(bus.br_op, bus.rs_ready, bus.rt_ready);
      tk  = modelTaken(bus.br_op, bus.rs_data, bus.rt_data);
      if (!reset) begin
         mInSlot    = 1'b0;
         mKill      = 1'b0;
         mSlotFirst = 1'b0;
         mBr        = 0;
         mTaken     = 0;
         mStall     = 0;
      end else if (mInSlot) begin
         mSlotFirst = 1'b0;
         if (!bus.id_hold) begin
            mInSlot = 1'b0;
            mKill   = 1'b0;
         end
      end else if (bus.br_valid) begin
         if (!rdy) begin
            mStall++;
         end else if (!bus.id_hold) begin
            mBr++;
            if (tk) mTaken++;
            mInSlot    = 1'b1;
            mSlotFirst = 1'b1;
            mKill      = bus.br_op[3] && !tk;
         end
      end
   endtask

   task automatic idleCycle(input logic rstN);
      applyStimulus(rstN, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 16'h0, 1'b0);
      endCycle();
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      int          sel;
      checks   = 0;
      failures = 0;
      mInSlot  = 1'b0;
      mKill    = 1'b0;
      mSlotFirst = 1'b0;
      mBr      = 0;
      mTaken   = 0;
      mStall   = 0;
      reset    = 1'b0;

      idleCycle(1'b0);
      idleCycle(1'b0);
      idleCycle(1'b1);

      // BEQ taken with redirect target 0x3014, then the delay slot.
      applyStimulus(1'b1, 1'b1, 4'h0, 32'h1234, 32'h1234, 1'b1, 1'b1, 32'h3000, 16'h0004, 1'b0);
      checkOutput("beq_redirect_pc", bus.redirect_pc, 32'h0000_3014);
      checkOutput("beq_redirect", {31'h0, bus.redirect_valid}, 32'h1);
      endCycle();
      idleCycle(1'b1);

      // BGEZ with the most negative rs is not taken; BLEZ with it is.
      applyStimulus(1'b1, 1'b1, 4'h5, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 32'h3000, 16'h0010, 1'b0);
      checkOutput("bgez_neg", {31'h0, bus.redirect_valid}, 32'h0);
      endCycle();
      idleCycle(1'b1);
      applyStimulus(1'b1, 1'b1, 4'h2, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 32'h3000, 16'hFFFF, 1'b0);
      checkOutput("blez_neg", {31'h0, bus.redirect_valid}, 32'h1);
      checkOutput("blez_back_pc", bus.redirect_pc, 32'h0000_3000);
      endCycle();
      idleCycle(1'b1);

      // BNE waiting two cycles for rt, from a fresh reset so the counters are absolute.
      idleCycle(1'b0);
      applyStimulus(1'b1, 1'b1, 4'h1, 32'h1, 32'h2, 1'b1, 1'b0, 32'h100, 16'h8, 1'b0);
      checkOutput("bne_wait1", {31'h0, bus.br_stall}, 32'h1);
      endCycle();
      applyStimulus(1'b1, 1'b1, 4'h1, 32'h1, 32'h2, 1'b1, 1'b0, 32'h100, 16'h8, 1'b0);
      checkOutput("bne_wait2", {31'h0, bus.br_stall}, 32'h1);
      endCycle();
      applyStimulus(1'b1, 1'b1, 4'h1, 32'h1, 32'h2, 1'b1, 1'b1, 32'h100, 16'h8, 1'b0);
      checkOutput("bne_taken", {31'h0, bus.redirect_valid}, 32'h1);
      endCycle();
      applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 16'h0, 1'b0);
      checkOutput("bne_stall_cnt", bus.stall_cnt, PERF ? 32'd2 : 32'd0);
      checkOutput("bne_br_cnt", bus.br_cnt, PERF ? 32'd1 : 32'd0);
      endCycle();

      // BEQL not taken: slot kill held across one id_hold cycle.
      applyStimulus(1'b1, 1'b1, 4'h8, 32'h5, 32'h6, 1'b1, 1'b1, 32'h200, 16'h4, 1'b0);
      checkOutput("beql_noredir", {31'h0, bus.redirect_valid}, 32'h0);
      endCycle();
      applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 16'h0, 1'b1);
      checkOutput("beql_kill1", {31'h0, bus.slot_kill}, 32'h1);
      endCycle();
      applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 16'h0, 1'b0);
      checkOutput("beql_kill2", {31'h0, bus.slot_kill}, 32'h1);
      endCycle();
      applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 16'h0, 1'b0);
      checkOutput("beql_kill_clr", {31'h0, bus.slot_kill}, 32'h0);
      endCycle();

      // Taken branch sitting in the delay slot of another taken branch.
      applyStimulus(1'b1, 1'b1, 4'h0, 32'h7, 32'h7, 1'b1, 1'b1, 32'h400, 16'h4, 1'b0);
      endCycle();
      applyStimulus(1'b1, 1'b1, 4'h0, 32'h9, 32'h9, 1'b1, 1'b1, 32'h404, 16'h4, 1'b0);
      checkOutput("slot_br_noredir", {31'h0, bus.redirect_valid}, 32'h0);
      checkOutput("slot_br_err", {31'h0, bus.slot_err}, 32'h1);
      endCycle();
      applyStimulus(1'b1, 1'b1, 4'h0, 32'h9, 32'h9, 1'b1, 1'b1, 32'h408, 16'h4, 1'b0);
      checkOutput("slot_br_idle_redir", {31'h0, bus.redirect_valid}, 32'h1);
      checkOutput("slot_br_err_clr", {31'h0, bus.slot_err}, 32'h0);
      endCycle();
      idleCycle(1'b1);

      // Reset while waiting on operands.
      applyStimulus(1'b1, 1'b1, 4'h1, 32'h1, 32'h2, 1'b1, 1'b0, 32'h500, 16'h4, 1'b0);
      endCycle();
      applyStimulus(1'b0, 1'b1, 4'h1, 32'h1, 32'h2, 1'b1, 1'b0, 32'h500, 16'h4, 1'b0);
      checkOutput("rst_wait_stall", {31'h0, bus.br_stall}, 32'h0);
      endCycle();
      applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 16'h0, 1'b0);
      checkOutput("rst_wait_kill", {31'h0, bus.slot_kill}, 32'h0);
      checkOutput("rst_wait_stall_cnt", bus.stall_cnt, 32'h0);
      checkOutput("rst_wait_br_cnt", bus.br_cnt, 32'h0);
      endCycle();

      // Randomized traffic; likely is only combined with defined ops.
      for (int i = 0; i < 600; i++) begin
         sel = $urandom_range(0, 7);
         op  = {1'b0, 3'(sel)};
         if (sel < 6) op[3] = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 4))
            0:       rs = 32'h0;
            1:       rs = 32'h8000_0000;
            2:       rs = 32'hFFFF_FFFF;
            3:       rs = 32'h1;
            default: rs = $urandom;
         endcase
         rt = ($urandom_range(0, 1) == 1) ? rs : $urandom;
         applyStimulus(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) < 7), op, rs, rt,
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                       $urandom, 16'($urandom), ($urandom_range(0, 3) == 0));
         endCycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
